// File: rtl/triangle_pkg.sv
// Shared types and constants for the triangle scheduler.
// Configuration macro used by this slice: TRI_WINDING_FIX_EN (see triangle_scheduler.sv).
package triangle_pkg;

    localparam int COORD_W = 12;
    localparam int NUM_TRI = 4;
    localparam int IDX_W   = $clog2(NUM_TRI);
    // Signed area needs one bit per difference sign plus one for the subtraction.
    localparam int AREA_W  = 2 * COORD_W + 3;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic signed [AREA_W-1:0] area_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef struct packed {
        vertex_t p1;
        vertex_t p2;
        vertex_t p3;
    } triangle_t;

    typedef triangle_t table_t [NUM_TRI];

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        AREA,
        WAIT_FRAME,
        COMMIT
    } state_t;

    localparam table_t DEFAULT_TABLE = '{
        '{p1: '{x: 12'd300, y: 12'd100}, p2: '{x: 12'd400,  y: 12'd300}, p3: '{x: 12'd600,  y: 12'd200}},
        '{p1: '{x: 12'd300, y: 12'd100}, p2: '{x: 12'd600,  y: 12'd400}, p3: '{x: 12'd800,  y: 12'd350}},
        '{p1: '{x: 12'd300, y: 12'd100}, p2: '{x: 12'd1000, y: 12'd500}, p3: '{x: 12'd1400, y: 12'd300}},
        '{p1: '{x: 12'd300, y: 12'd100}, p2: '{x: 12'd1000, y: 12'd500}, p3: '{x: 12'd1400, y: 12'd100}}
    };

endpackage

// File: rtl/triangle_area.sv
// One registered stage computing the signed doubled area of a triangle
// and whether it is degenerate (zero area).
module triangle_area
    import triangle_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      en_i,
    input  triangle_t tri_i,
    output area_t     area_o,
    output logic      degen_o
);

    logic signed [COORD_W:0] d21x;
    logic signed [COORD_W:0] d21y;
    logic signed [COORD_W:0] d31x;
    logic signed [COORD_W:0] d31y;
    area_t                   area_c;
    area_t                   area_q;
    logic                    degen_q;

    // Coordinates are unsigned; zero-extend before subtracting so differences keep their sign.
    assign d21x = $signed({1'b0, tri_i.p2.x}) - $signed({1'b0, tri_i.p1.x});
    assign d21y = $signed({1'b0, tri_i.p2.y}) - $signed({1'b0, tri_i.p1.y});
    assign d31x = $signed({1'b0, tri_i.p3.x}) - $signed({1'b0, tri_i.p1.x});
    assign d31y = $signed({1'b0, tri_i.p3.y}) - $signed({1'b0, tri_i.p1.y});

    assign area_c = (area_t'(d21x) * area_t'(d31y)) - (area_t'(d31x) * area_t'(d21y));

    // Capture the area of the presented triangle when enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            area_q  <= '0;
            degen_q <= 1'b0;
        end else if (en_i) begin
            area_q  <= area_c;
            degen_q <= (area_c == area_t'(0));
        end
    end

    assign area_o  = area_q;
    assign degen_o = degen_q;

endmodule

// File: rtl/triangle_scheduler.sv
// Steps through a small writable triangle table on a dwell timer or key press,
// computes each entry's area and commits its vertices only at a frame boundary.
// Configuration macro: TRI_WINDING_FIX_EN -- when defined, triangles with positive
// area are committed with p2/p3 exchanged and swapped is raised.
module triangle_scheduler
    import triangle_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 35_000_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               step_key_n,
    input  logic               pause,
    input  logic               frame_start,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_vtx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    output logic [COORD_W-1:0] p1_x,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] p2_x,
    output logic [COORD_W-1:0] p2_y,
    output logic [COORD_W-1:0] p3_x,
    output logic [COORD_W-1:0] p3_y,
    output logic [IDX_W-1:0]   tri_idx,
    output logic               busy,
    output logic               degen,
    output logic               swapped
);

    localparam int               CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] dwell_q;
    logic [IDX_W-1:0] next_idx_q;
    logic [IDX_W-1:0] next_idx_d;
    logic [IDX_W-1:0] tri_idx_q;
    triangle_t        shadow_q;
    triangle_t        out_q;
    table_t           table_q;
    logic             busy_q;
    logic             degen_q;
    logic             key_meta_q;
    logic             key_sync_q;
    logic             key_prev_q;
    logic             key_fall;
    logic             dwell_hit;
    logic             advance;
    area_t            area_val;
    logic             area_degen;

    // Synchronise the raw key and keep one delayed copy for falling-edge detection.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RESET_N) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            key_meta_q <= step_key_n;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    assign key_fall   = key_prev_q & ~key_sync_q;
    assign dwell_hit  = (dwell_q == DWELL_LAST);
    assign advance    = key_fall | dwell_hit;
    // Table size is a power of two, so the increment wraps naturally.
    assign next_idx_d = tri_idx_q + IDX_W'(1);

    // Triangle table: reloads defaults on reset, cfg writes land on the next edge.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: the table is small and must come back to known defaults, so it is reset like plain registers.
        if (!RESET_N) begin
            table_q <= DEFAULT_TABLE;
        end else if (cfg_we) begin
            case (cfg_vtx)
                2'd0:    table_q[cfg_idx].p1 <= '{x: cfg_x, y: cfg_y};
                2'd1:    table_q[cfg_idx].p2 <= '{x: cfg_x, y: cfg_y};
                2'd2:    table_q[cfg_idx].p3 <= '{x: cfg_x, y: cfg_y};
                default: ;
            endcase
        end
    end

    triangle_area u_area (
        .clk_i   (CLOCK_50),
        .rst_n_i (RESET_N),
        .en_i    (state_q == AREA),
        .tri_i   (shadow_q),
        .area_o  (area_val),
        .degen_o (area_degen)
    );

`ifdef TRI_WINDING_FIX_EN
    logic swapped_q;
`else
    logic unused_area;
    assign unused_area = ^area_val;
`endif

    // Sequencer FSM with registered outputs; dwell counter only runs in IDLE.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            next_idx_q <= '0;
            tri_idx_q  <= '0;
            shadow_q   <= DEFAULT_TABLE[0];
            out_q      <= DEFAULT_TABLE[0];
            busy_q     <= 1'b0;
            degen_q    <= 1'b0;
`ifdef TRI_WINDING_FIX_EN
            swapped_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (advance) begin
                        dwell_q    <= '0;
                        next_idx_q <= next_idx_d;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end else if (!pause) begin
                        dwell_q <= dwell_q + CNT_W'(1);
                    end
                end
                LOAD: begin
                    shadow_q <= table_q[next_idx_q];
                    state_q  <= AREA;
                end
                AREA: begin
                    state_q <= WAIT_FRAME;
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    out_q     <= shadow_q;
                    tri_idx_q <= next_idx_q;
                    degen_q   <= area_degen;
`ifdef TRI_WINDING_FIX_EN
                    swapped_q <= (area_val > area_t'(0));
                    if (area_val > area_t'(0)) begin
                        out_q.p2 <= shadow_q.p3;
                        out_q.p3 <= shadow_q.p2;
                    end
`endif
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p1_x    = out_q.p1.x;
    assign p1_y    = out_q.p1.y;
    assign p2_x    = out_q.p2.x;
    assign p2_y    = out_q.p2.y;
    assign p3_x    = out_q.p3.x;
    assign p3_y    = out_q.p3.y;
    assign tri_idx = tri_idx_q;
    assign busy    = busy_q;
    assign degen   = degen_q;
`ifdef TRI_WINDING_FIX_EN
    assign swapped = swapped_q;
`else
    assign swapped = 1'b0;
`endif

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed testbench for triangle_scheduler with hand-computed expectations.
// Honours TRI_WINDING_FIX_EN for the winding-fix expectations.
module tb_triangle_scheduler;

    logic        clk;
    logic        rst_n;
    logic        step_key_n;
    logic        pause;
    logic        frame_start;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [1:0]  cfg_vtx;
    logic [11:0] cfg_x;
    logic [11:0] cfg_y;
    logic [11:0] p1_x, p1_y, p2_x, p2_y, p3_x, p3_y;
    logic [1:0]  tri_idx;
    logic        busy;
    logic        degen;
    logic        swapped;

    int total = 0;
    int bad   = 0;

    triangle_scheduler #(.DWELL_CYCLES(16)) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .step_key_n  (step_key_n),
        .pause       (pause),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_vtx     (cfg_vtx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .p3_x        (p3_x),
        .p3_y        (p3_y),
        .tri_idx     (tri_idx),
        .busy        (busy),
        .degen       (degen),
        .swapped     (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int idx,
                              input int x1, input int y1, input int x2, input int y2,
                              input int x3, input int y3);
        check({tag, "_idx"}, 32'(tri_idx), idx);
        check({tag, "_p1x"}, 32'(p1_x), x1);
        check({tag, "_p1y"}, 32'(p1_y), y1);
        check({tag, "_p2x"}, 32'(p2_x), x2);
        check({tag, "_p2y"}, 32'(p2_y), y2);
        check({tag, "_p3x"}, 32'(p3_x), x3);
        check({tag, "_p3y"}, 32'(p3_y), y3);
    endtask

    // Key held low long enough to pass the synchroniser, then released.
    task automatic press_key();
        step_key_n = 1'b0;
        repeat (4) tick();
        step_key_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic advance();
        press_key();
        pulse_frame();
        tick();
    endtask

    task automatic cfg_write(input int idx, input int vtx, input int x, input int y);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_vtx = 2'(vtx);
        cfg_x   = 12'(x);
        cfg_y   = 12'(y);
        tick();
        cfg_we  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        step_key_n  = 1'b1;
        pause       = 1'b0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        cfg_idx     = '0;
        cfg_vtx     = '0;
        cfg_x       = '0;
        cfg_y       = '0;
        repeat (3) tick();

        // Reset values
        expect_out("rst", 0, 300, 100, 400, 300, 600, 200);
        check("rst_busy", 32'(busy), 0);
        check("rst_degen", 32'(degen), 0);
        check("rst_swapped", 32'(swapped), 0);

        // Dwell advance: 16 idle cycles after reset release
        rst_n = 1'b1;
        n = 0;
        while (!busy && n < 40) begin
            tick();
            n++;
        end
        check("dwell_cycles", 32'(n), 16);
        pause = 1'b1;
        repeat (4) tick();
        check("wait_busy", 32'(busy), 1);
        check("wait_hold_p2x", 32'(p2_x), 400);
        pulse_frame();
        check("pre_commit_p2x", 32'(p2_x), 400);
        tick();
        expect_out("dwell1", 1, 300, 100, 600, 400, 800, 350);
        check("dwell1_busy", 32'(busy), 0);
        check("dwell1_degen", 32'(degen), 0);
        check("dwell1_swapped", 32'(swapped), 0);

        // Busy timing on a key press: advance event is two edges after the key falls
        step_key_n = 1'b0;
        tick();
        tick();
        check("busy_before", 32'(busy), 0);
        tick();
        check("busy_after", 32'(busy), 1);
        tick();
        step_key_n = 1'b1;
        repeat (4) tick();
        pulse_frame();
        tick();
        expect_out("key2", 2, 300, 100, 1000, 500, 1400, 300);
        check("key2_busy", 32'(busy), 0);

        // Further key steps with pause high, including wrap 3 -> 0
        advance();
        expect_out("key3", 3, 300, 100, 1000, 500, 1400, 100);
        advance();
        expect_out("key0", 0, 300, 100, 400, 300, 600, 200);
        advance();
        check("key1_idx", 32'(tri_idx), 1);

        // Second key press while busy is ignored
        press_key();
        press_key();
        pulse_frame();
        tick();
        check("busy_key_idx", 32'(tri_idx), 2);
        repeat (10) tick();
        check("busy_key_idle", 32'(busy), 0);
        check("busy_key_hold", 32'(tri_idx), 2);

        // Winding: entry 1 reordered gives A = +75000
        cfg_write(1, 1, 800, 350);
        cfg_write(1, 2, 600, 400);
        advance();
        advance();
        advance();
`ifdef TRI_WINDING_FIX_EN
        expect_out("wind", 1, 300, 100, 600, 400, 800, 350);
        check("wind_swapped", 32'(swapped), 1);
`else
        expect_out("wind", 1, 300, 100, 800, 350, 600, 400);
        check("wind_swapped", 32'(swapped), 0);
`endif
        check("wind_degen", 32'(degen), 0);

        // A table write never disturbs committed outputs
        cfg_write(1, 0, 5, 5);
        tick();
        check("write_no_disturb", 32'(p1_x), 300);

        // Degenerate entry 2: A = 0
        cfg_write(2, 2, 1700, 900);
        advance();
        expect_out("degen", 2, 300, 100, 1000, 500, 1700, 900);
        check("degen_flag", 32'(degen), 1);
        check("degen_swapped", 32'(swapped), 0);

        // Reset mid-WAIT_FRAME
        press_key();
        check("rst_wait_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        expect_out("rstw", 0, 300, 100, 400, 300, 600, 200);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_degen", 32'(degen), 0);
        rst_n = 1'b1;
        pulse_frame();
        tick();
        check("rstw_frame_idx", 32'(tri_idx), 0);
        check("rstw_frame_p2x", 32'(p2_x), 400);
        check("rstw_frame_busy", 32'(busy), 0);

        // Table was reloaded by reset
        advance();
        expect_out("reload", 1, 300, 100, 600, 400, 800, 350);
        check("reload_swapped", 32'(swapped), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
